// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a per-owner hold limit.
// A registered owner index plus a grant state drive a one-hot grant decode.
module rr_arb4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  localparam int unsigned CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD != 0) ? CW'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   hold_q, hold_d;

  logic [3:0]      owner_hot_s;
  logic [3:0]      others_s;
  logic            owner_req_s;
  logic            expire_s;

  function automatic logic [3:0] dec(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  // First requester found scanning base, base+1, ... with 2-bit wrap.
  function automatic logic [1:0] pick(input logic [1:0] base, input logic [3:0] r);
    logic [1:0] idx;
    logic [1:0] win;
    win = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      win = r[idx] ? idx : win;
    end
    return win;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      idx_q   <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state and next-owner selection; disable overrides every other event.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    owner_hot_s = dec(idx_q);
    others_s    = req & ~owner_hot_s;
    owner_req_s = |(req & owner_hot_s);
    expire_s    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
    if (!en) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            idx_d   = pick(ptr_q, req);
            hold_d  = '0;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
        GRANT: begin
          if (!owner_req_s) begin
            ptr_d  = idx_q + 2'd1;
            hold_d = '0;
            if (|others_s) begin
              idx_d = pick(idx_q + 2'd1, others_s);
            end else begin
              state_d = IDLE;
            end
          end else if (expire_s && (|others_s)) begin
            ptr_d  = idx_q + 2'd1;
            idx_d  = pick(idx_q + 2'd1, others_s);
            hold_d = '0;
          end else if (expire_s) begin
            hold_d = hold_q;
          end else begin
            hold_d = hold_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Outputs decode straight from registers, so they clear with the async reset.
  always_comb begin
    gnt_vld = (state_q == GRANT);
    gnt_idx = idx_q;
    if (state_q == GRANT) begin
      gnt = dec(idx_q);
    end else begin
      gnt = 4'b0000;
    end
  end

endmodule
